// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with NZCV flags and err.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready operation handshake; A, B, ALUControl are sampled on accept
//   out_valid/out_ready result handshake; Result, Z, N, V, C, err held while out_valid
//
// Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra,
//          A mul, B divu, C remu (multi-cycle), D-F illegal.
//
// Build option: define ALU_MULDIV_EN to build the iterative mul/divu/remu unit
// (WIDTH cycles per op). Without it, opcodes A-C complete in one cycle as illegal.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C,
    output logic             err
);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSlt  = 4'b0101;
    localparam logic [3:0] OpSltu = 4'b0110;
    localparam logic [3:0] OpSll  = 4'b0111;
    localparam logic [3:0] OpSrl  = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1001;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OpMul  = 4'b1010;
    localparam logic [3:0] OpDivu = 4'b1011;
    localparam logic [3:0] OpRemu = 4'b1100;
`endif

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDone = 2'd1
`ifdef ALU_MULDIV_EN
        , StBusy = 2'd2
`endif
    } state_e;

    state_e r_state, w_state_d, w_start_state;

    logic             r_z, r_n, r_v, r_c, r_err;
    logic [WIDTH-1:0] r_result;
    logic             w_accept;
    logic             w_is_multi;

    // ---------------- single-cycle datapath (operates on live inputs) ----------------
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH:0]   w_addsub;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_c, w_sc_v, w_sc_err;

    assign w_is_sub = (ALUControl == OpSub);
    assign w_b_op   = w_is_sub ? ~B : B;
    // Sub is A + ~B + 1, so C=1 means no borrow.
    assign w_addsub = {1'b0, A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
    assign w_shamt  = B[SHW-1:0];

    always_comb begin
        w_sc_res = '0;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        w_sc_err = 1'b0;
        case (ALUControl)
            OpAdd, OpSub: begin
                w_sc_res = w_addsub[WIDTH-1:0];
                w_sc_c   = w_addsub[WIDTH];
                // Overflow: both addends share a sign that the sum does not.
                w_sc_v   = ~(A[WIDTH-1] ^ w_b_op[WIDTH-1]) & (A[WIDTH-1] ^ w_sc_res[WIDTH-1]);
            end
            OpAnd:   w_sc_res = A & B;
            OpOr:    w_sc_res = A | B;
            OpXor:   w_sc_res = A ^ B;
            OpSlt:   w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OpSltu:  w_sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OpSll:   w_sc_res = A << w_shamt;
            OpSrl:   w_sc_res = A >> w_shamt;
            OpSra:   w_sc_res = $signed(A) >>> w_shamt;
            default: w_sc_err = 1'b1;
        endcase
    end

    // ---------------- iterative mul/div datapath ----------------
`ifdef ALU_MULDIV_EN
    logic [3:0]       r_op;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_a;    // mul: multiplicand (shifts left); div: divisor
    logic [WIDTH-1:0] r_b;    // mul: multiplier (shifts right); div: dividend -> quotient
    logic [WIDTH-1:0] r_acc;  // mul: partial product; div: partial remainder
    logic             w_last;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_rem_sh, w_rem_sub;
    logic             w_rem_ge;
    logic [WIDTH-1:0] w_div_rem, w_div_q, w_mc_res;

    assign w_is_multi    = (ALUControl == OpMul) || (ALUControl == OpDivu) ||
                           (ALUControl == OpRemu);
    assign w_start_state = w_is_multi ? StBusy : StDone;
    assign w_last        = (r_cnt == SHW'(WIDTH - 1));

    assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);
    // Restoring divide; a zero divisor always "fits", giving all-ones quotient and remainder A.
    assign w_rem_sh  = {r_acc, r_b[WIDTH-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_a};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_a});
    assign w_div_rem = w_rem_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_div_q   = {r_b[WIDTH-2:0], w_rem_ge};

    always_comb begin
        case (r_op)
            OpMul:   w_mc_res = w_mul_acc;
            OpDivu:  w_mc_res = w_div_q;
            default: w_mc_res = w_div_rem;
        endcase
    end
`else
    assign w_is_multi    = 1'b0;
    assign w_start_state = StDone;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= StIdle;
        else      r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        in_ready  = 1'b0;
        case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) w_state_d = w_start_state;
            end
`ifdef ALU_MULDIV_EN
            StBusy: begin
                if (w_last) w_state_d = StDone;
            end
`endif
            StDone: begin
                in_ready = out_ready;
                if (out_ready) w_state_d = in_valid ? w_start_state : StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    // ---------------- result / operand registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_MULDIV_EN
            r_op     <= OpAdd;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
`endif
        end else if (w_accept && !w_is_multi) begin
            r_result <= w_sc_res;
            r_z      <= (w_sc_res == '0);
            r_n      <= w_sc_res[WIDTH-1];
            r_v      <= w_sc_v;
            r_c      <= w_sc_c;
            r_err    <= w_sc_err;
        end
`ifdef ALU_MULDIV_EN
        else if (w_accept) begin
            r_op  <= ALUControl;
            r_cnt <= '0;
            r_acc <= '0;
            if (ALUControl == OpMul) begin
                r_a <= A;
                r_b <= B;
            end else begin
                r_a <= B;
                r_b <= A;
            end
        end else if (r_state == StBusy) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op == OpMul) begin
                r_acc <= w_mul_acc;
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
            end else begin
                r_acc <= w_div_rem;
                r_b   <= w_div_q;
            end
            if (w_last) begin
                r_result <= w_mc_res;
                r_z      <= (w_mc_res == '0);
                r_n      <= w_mc_res[WIDTH-1];
                r_v      <= 1'b0;
                r_c      <= 1'b0;
                r_err    <= (r_op != OpMul) && (r_a == '0);
            end
        end
`endif
    end

    assign out_valid = (r_state == StDone);
    assign Result    = r_result;
    assign Z         = r_z;
    assign N         = r_n;
    assign V         = r_v;
    assign C         = r_c;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32).
// Multi-cycle cases are compiled in when ALU_MULDIV_EN is defined; otherwise
// opcodes A-C are checked as single-cycle illegal ops.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALUControl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;
    logic         Z, N, V, C, err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUControl(ALUControl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Z         (Z),
        .N         (N),
        .V         (V),
        .C         (C),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Flags packed as {Z,N,V,C,err}.
    task automatic expect_res(input string tag, input logic [31:0] res,
                              input logic z, input logic n, input logic v,
                              input logic c, input logic e);
        check({tag, "/valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "/result"}, Result, res);
        check({tag, "/flags"}, {27'b0, Z, N, V, C, err}, {27'b0, z, n, v, c, e});
    endtask

    // Called #1 after a posedge with in_ready high. Returns the number of edges
    // after the accept edge until out_valid is seen (bounded).
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n_cyc);
        in_valid   = 1'b1;
        A          = a;
        B          = b;
        ALUControl = op;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        A          = '1;      // must not affect an accepted op
        B          = '1;
        ALUControl = 4'hF;
        n_cyc = 0;
        while (!out_valid && n_cyc < 100) begin
            @(posedge clk);
            #1;
            n_cyc++;
        end
    endtask

    initial begin
        logic seen;
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        A          = '0;
        B          = '0;
        ALUControl = 4'h0;

        // Reset state
        #2;
        check("rst/valid", {31'b0, out_valid}, 32'd0);
        check("rst/result", Result, 32'd0);
        check("rst/flags", {27'b0, Z, N, V, C, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("rst/in_ready", {31'b0, in_ready}, 32'd1);

        // Single-cycle ops
        do_op(4'h0, 32'h7FFF_FFFF, 32'h1, cyc);
        check("add_ovf/lat", cyc, 0);
        expect_res("add_ovf", 32'h8000_0000, 0, 1, 1, 0, 0);
        do_op(4'h0, 32'hFFFF_FFFF, 32'h1, cyc);
        expect_res("add_carry", 32'h0, 1, 0, 0, 1, 0);
        do_op(4'h1, 32'd5, 32'd5, cyc);
        expect_res("sub_eq", 32'h0, 1, 0, 0, 1, 0);
        do_op(4'h1, 32'd0, 32'd1, cyc);
        expect_res("sub_borrow", 32'hFFFF_FFFF, 0, 1, 0, 0, 0);
        do_op(4'h1, 32'h8000_0000, 32'd1, cyc);
        expect_res("sub_ovf", 32'h7FFF_FFFF, 0, 0, 1, 1, 0);
        do_op(4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, cyc);
        expect_res("and", 32'hF000_F000, 0, 1, 0, 0, 0);
        do_op(4'h3, 32'h0000_00F0, 32'h0000_000F, cyc);
        expect_res("or", 32'h0000_00FF, 0, 0, 0, 0, 0);
        do_op(4'h4, 32'hAAAA_5555, 32'hFFFF_0000, cyc);
        expect_res("xor", 32'h5555_5555, 0, 0, 0, 0, 0);
        do_op(4'h5, 32'h1, 32'hFFFF_FFFF, cyc);
        expect_res("slt_0", 32'h0, 1, 0, 0, 0, 0);
        do_op(4'h5, 32'hFFFF_FFFF, 32'h1, cyc);
        expect_res("slt_1", 32'h1, 0, 0, 0, 0, 0);
        do_op(4'h6, 32'h1, 32'hFFFF_FFFF, cyc);
        expect_res("sltu", 32'h1, 0, 0, 0, 0, 0);
        do_op(4'h7, 32'h1, 32'h21, cyc);
        expect_res("sll", 32'h2, 0, 0, 0, 0, 0);
        do_op(4'h8, 32'h8000_0000, 32'd31, cyc);
        expect_res("srl", 32'h1, 0, 0, 0, 0, 0);
        do_op(4'h9, 32'h8000_0000, 32'h24, cyc);
        expect_res("sra", 32'hF800_0000, 0, 1, 0, 0, 0);
        do_op(4'hF, 32'h1234, 32'h5678, cyc);
        check("ill_f/lat", cyc, 0);
        expect_res("ill_f", 32'h0, 1, 0, 0, 0, 1);
        do_op(4'hD, 32'h1, 32'h1, cyc);
        expect_res("ill_d", 32'h0, 1, 0, 0, 0, 1);
        do_op(4'h0, 32'h2, 32'h3, cyc);
        expect_res("err_clear", 32'h5, 0, 0, 0, 0, 0);

`ifdef ALU_MULDIV_EN
        do_op(4'hA, 32'h0001_0000, 32'h0001_0000, cyc);
        check("mul_wrap/lat", cyc, 32);
        expect_res("mul_wrap", 32'h0, 1, 0, 0, 0, 0);
        do_op(4'hA, 32'd7, 32'd9, cyc);
        expect_res("mul_7x9", 32'd63, 0, 0, 0, 0, 0);
        do_op(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        expect_res("mul_neg", 32'h1, 0, 0, 0, 0, 0);
        do_op(4'hB, 32'd100, 32'd7, cyc);
        check("divu/lat", cyc, 32);
        expect_res("divu", 32'd14, 0, 0, 0, 0, 0);
        do_op(4'hC, 32'd100, 32'd7, cyc);
        expect_res("remu", 32'd2, 0, 0, 0, 0, 0);
        do_op(4'hB, 32'd5, 32'd0, cyc);
        check("divu0/lat", cyc, 32);
        expect_res("divu0", 32'hFFFF_FFFF, 0, 1, 0, 0, 1);
        do_op(4'hC, 32'd5, 32'd0, cyc);
        expect_res("remu0", 32'd5, 0, 0, 0, 0, 1);
        do_op(4'hB, 32'hFFFF_FFFF, 32'd1, cyc);
        expect_res("divu_big", 32'hFFFF_FFFF, 0, 1, 0, 0, 0);
`else
        do_op(4'hB, 32'd100, 32'd7, cyc);
        check("nomd_b/lat", cyc, 0);
        expect_res("nomd_b", 32'h0, 1, 0, 0, 0, 1);
        do_op(4'hA, 32'd7, 32'd9, cyc);
        check("nomd_a/lat", cyc, 0);
        expect_res("nomd_a", 32'h0, 1, 0, 0, 0, 1);
`endif

        // Retire with no new op -> idle
        @(posedge clk);
        #1;
        check("retire/valid", {31'b0, out_valid}, 32'd0);
        check("retire/in_ready", {31'b0, in_ready}, 32'd1);

        // Backpressure
        out_ready = 1'b0;
        do_op(4'h0, 32'd3, 32'd4, cyc);
        expect_res("bp_add", 32'd7, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp/hold_result", Result, 32'd7);
            check("bp/in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid   = 1'b1;
        A          = 32'h0F0;
        B          = 32'h00F;
        ALUControl = 4'h3;
        out_ready  = 1'b1;
        #1;
        check("bp/in_ready_rel", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_res("bp_or", 32'h0FF, 0, 0, 0, 0, 0);

        // Reset while holding a result
        out_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_done/valid", {31'b0, out_valid}, 32'd0);
        check("rst_done/result", Result, 32'd0);
        #3 rst = 1'b1;
        check("rst_done/in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;

`ifdef ALU_MULDIV_EN
        // Reset mid-BUSY: accepted mul must never surface
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        A          = 32'd7;
        B          = 32'd9;
        ALUControl = 4'hA;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_busy/valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy/result", Result, 32'd0);
        #3 rst = 1'b1;
        check("rst_busy/in_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("rst_busy/no_stale", {31'b0, seen}, 32'd0);
        check("rst_busy/result_after", Result, 32'd0);
`else
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("rst_done/no_stale", {31'b0, seen}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
